// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : MIPS writeback stage and 32x32 general-purpose register file.
//               Decodes the WB target, extends load data, writes the register
//               file and counts retired (non-bubble) instructions.
//               Optional macro WB_BYPASS_EN enables write-through bypass
//               on both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int          NREG     = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] PC4_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic        movz_W,
  input  logic        bge_W,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WE_W,
  output logic [4:0]  WA_W,
  output logic [31:0] WD_W,
  output logic [31:0] RETIRED
);

  // Primary opcodes
  localparam logic [5:0] c_OP_SPECIAL = 6'h00;
  localparam logic [5:0] c_OP_REGIMM  = 6'h01;
  localparam logic [5:0] c_OP_JAL     = 6'h03;
  localparam logic [5:0] c_OP_ADDIU   = 6'h09;
  localparam logic [5:0] c_OP_SLTI    = 6'h0A;
  localparam logic [5:0] c_OP_ORI     = 6'h0D;
  localparam logic [5:0] c_OP_LUI     = 6'h0F;
  localparam logic [5:0] c_OP_LB      = 6'h20;
  localparam logic [5:0] c_OP_LH      = 6'h21;
  localparam logic [5:0] c_OP_LW      = 6'h23;
  localparam logic [5:0] c_OP_LBU     = 6'h24;
  localparam logic [5:0] c_OP_LHU     = 6'h25;
  // SPECIAL function codes
  localparam logic [5:0] c_FN_SLL     = 6'h00;
  localparam logic [5:0] c_FN_JALR    = 6'h09;
  localparam logic [5:0] c_FN_MOVZ    = 6'h0A;
  localparam logic [5:0] c_FN_ADDU    = 6'h21;
  localparam logic [5:0] c_FN_SUBU    = 6'h23;
  localparam logic [5:0] c_FN_AND     = 6'h24;
  localparam logic [5:0] c_FN_OR      = 6'h25;
  localparam logic [5:0] c_FN_SLT     = 6'h2A;
  // REGIMM rt code for the bgezal class; link register
  localparam logic [4:0] c_RT_BGEZAL  = 5'h11;
  localparam logic [4:0] c_REG_RA     = 5'd31;

  logic [31:0] r_regs [NREG];
  logic [31:0] r_retired;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_link;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_wr;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;
  logic [31:0] w_rf1;
  logic [31:0] w_rf2;
  logic        w_unused_ok;

  assign w_op   = IR_W[31:26];
  assign w_rt   = IR_W[20:16];
  assign w_rd   = IR_W[15:11];
  assign w_fn   = IR_W[5:0];
  // Link value: address of the instruction after the delay slot (wraps mod 2^32)
  assign w_link = PC4_W + 32'd4;
  // Halfword lane chosen by address bit 1 (little-endian)
  assign w_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];

  // rs and shamt fields are not needed here; PC_RESET only documents bubbles
  assign w_unused_ok = ^{IR_W[25:21], IR_W[10:6], (PC4_W == PC_RESET)};

  // Byte lane select from the aligned memory word (little-endian)
  always_comb begin
    w_byte = DR_W[7:0];
    case (AO_W[1:0])
      2'd0:    w_byte = DR_W[7:0];
      2'd1:    w_byte = DR_W[15:8];
      2'd2:    w_byte = DR_W[23:16];
      default: w_byte = DR_W[31:24];
    endcase
  end

  // Writeback decode: target register, data and raw write request
  always_comb begin
    w_wr = 1'b0;
    w_wa = 5'd0;
    w_wd = AO_W;
    case (w_op)
      c_OP_SPECIAL: begin
        case (w_fn)
          c_FN_ADDU, c_FN_SUBU, c_FN_AND, c_FN_OR, c_FN_SLT, c_FN_SLL: begin
            w_wr = 1'b1;
            w_wa = w_rd;
          end
          c_FN_MOVZ: begin
            w_wr = movz_W;
            w_wa = w_rd;
          end
          c_FN_JALR: begin
            w_wr = 1'b1;
            w_wa = w_rd;
            w_wd = w_link;
          end
          default: ;
        endcase
      end
      c_OP_ORI, c_OP_ADDIU, c_OP_LUI, c_OP_SLTI: begin
        w_wr = 1'b1;
        w_wa = w_rt;
      end
      c_OP_LW: begin
        w_wr = 1'b1;
        w_wa = w_rt;
        w_wd = DR_W;
      end
      c_OP_LB: begin
        w_wr = 1'b1;
        w_wa = w_rt;
        w_wd = {{24{w_byte[7]}}, w_byte};
      end
      c_OP_LBU: begin
        w_wr = 1'b1;
        w_wa = w_rt;
        w_wd = {24'd0, w_byte};
      end
      c_OP_LH: begin
        w_wr = 1'b1;
        w_wa = w_rt;
        w_wd = {{16{w_half[15]}}, w_half};
      end
      c_OP_LHU: begin
        w_wr = 1'b1;
        w_wa = w_rt;
        w_wd = {16'd0, w_half};
      end
      c_OP_JAL: begin
        w_wr = 1'b1;
        w_wa = c_REG_RA;
        w_wd = w_link;
      end
      c_OP_REGIMM: begin
        if (w_rt == c_RT_BGEZAL) begin
          w_wr = bge_W;
          w_wa = c_REG_RA;
          w_wd = w_link;
        end
      end
      default: ;
    endcase
  end

  // $0 is hardwired: a write aimed at it is dropped and not advertised
  assign WE_W = w_wr && (w_wa != 5'd0);
  assign WA_W = w_wa;
  assign WD_W = w_wd;

  // Register file storage; cleared asynchronously, written on the rising edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (WE_W) begin
      r_regs[WA_W] <= WD_W;
    end
  end

  // Retired-instruction counter; bubbles (IR_W == 0) are not counted
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_retired <= 32'd0;
    end else if (IR_W != 32'd0) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign RETIRED = r_retired;

  // Combinational read of stored contents; $0 always reads zero
  always_comb begin
    w_rf1 = (RA1 == 5'd0) ? 32'd0 : r_regs[RA1];
    w_rf2 = (RA2 == 5'd0) ? 32'd0 : r_regs[RA2];
  end

`ifdef WB_BYPASS_EN
  // Write-through: a same-cycle WB write to the addressed register wins
  assign RD1 = (WE_W && (RA1 == WA_W)) ? WD_W : w_rf1;
  assign RD2 = (WE_W && (RA2 == WA_W)) ? WD_W : w_rf2;
`else
  // No bypass: the hazard unit stalls or forwards from WD_W externally
  assign RD1 = w_rf1;
  assign RD2 = w_rf2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Expected register values
//               are queued when an instruction is issued and compared when
//               read back through the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] DR_PAT   = 32'h80FF_7F01;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IR_W, PC4_W, AO_W, DR_W;
  logic        movz_W, bge_W;
  logic [4:0]  RA1, RA2;
  logic [31:0] RD1, RD2;
  logic        WE_W;
  logic [4:0]  WA_W;
  logic [31:0] WD_W;
  logic [31:0] RETIRED;

  wb_regfile #(
    .NREG     (32),
    .PC_RESET (PC_RESET)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .IR_W    (IR_W),
    .PC4_W   (PC4_W),
    .AO_W    (AO_W),
    .DR_W    (DR_W),
    .movz_W  (movz_W),
    .bge_W   (bge_W),
    .RA1     (RA1),
    .RA2     (RA2),
    .RD1     (RD1),
    .RD2     (RD2),
    .WE_W    (WE_W),
    .WA_W    (WA_W),
    .WD_W    (WD_W),
    .RETIRED (RETIRED)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_ret    = 32'd0;
  logic        s_we;
  logic [4:0]  s_wa;
  logic [31:0] s_wd, s_rd1, s_rd2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0010};
  endfunction

  task automatic bubble();
    IR_W = 32'd0; PC4_W = PC_RESET; AO_W = 32'd0; DR_W = 32'd0;
    movz_W = 1'b0; bge_W = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] addr, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.addr = addr; e.val = val;
    sb.push_back(e);
  endtask

  // Present one instruction for one cycle; snapshot WB/read outputs mid-cycle
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] ao, input logic [31:0] dr,
                       input logic mz, input logic bg);
    IR_W = ir; PC4_W = pc4; AO_W = ao; DR_W = dr; movz_W = mz; bge_W = bg;
    #2;
    s_we = WE_W; s_wa = WA_W; s_wd = WD_W; s_rd1 = RD1; s_rd2 = RD2;
    @(posedge Clk); #1;
    if (Reset && ir != 32'd0) m_ret++;
    bubble();
  endtask

  // Pop queued expectations and compare against register contents
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      RA1 = e.addr;
      #1;
      check(e.tag, RD1, e.val);
    end
    check("retired", RETIRED, m_ret);
    @(posedge Clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; bubble(); RA1 = 5'd0; RA2 = 5'd0;
    #3;
    check("rst_retired", RETIRED, 32'd0);
    RA1 = 5'd5; #1;
    check("rst_rd5", RD1, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;

    // $5 = 0x1234, then asynchronous reset mid-run
    expect_reg("ori5", 5'd5, 32'h1234);
    drive(f_i(6'h0D, 5'd5), PC_RESET, 32'h1234, 32'd0, 1'b0, 1'b0);
    drain();
    Reset = 1'b0; RA1 = 5'd5; #1;
    check("midrst_rd5", RD1, 32'd0);
    check("midrst_retired", RETIRED, 32'd0);
    m_ret = 32'd0;
    drive(f_i(6'h0D, 5'd6), PC_RESET, 32'h99, 32'd0, 1'b0, 1'b0);
    Reset = 1'b1;
    expect_reg("noinrst6", 5'd6, 32'd0);
    drain();

    // ori $3, then addu to $0
    expect_reg("ori3", 5'd3, 32'h0000ABCD);
    drive(f_i(6'h0D, 5'd3), PC_RESET, 32'h0000ABCD, 32'd0, 1'b0, 1'b0);
    check("ori3_we", {31'd0, s_we}, 32'd1);
    check("ori3_wa", {27'd0, s_wa}, 32'd3);
    check("ori3_wd", s_wd, 32'h0000ABCD);
    drain();
    expect_reg("addu0", 5'd0, 32'd0);
    drive(f_r(5'd0, 6'h21), PC_RESET, 32'h77, 32'd0, 1'b0, 1'b0);
    check("addu0_we", {31'd0, s_we}, 32'd0);
    drain();

    // Loads from 0x80FF7F01 with various byte offsets
    expect_reg("lb_off2",  5'd10, 32'hFFFFFFFF);
    drive(f_i(6'h20, 5'd10), PC_RESET, 32'h1002, DR_PAT, 1'b0, 1'b0);
    expect_reg("lbu_off3", 5'd11, 32'h00000080);
    drive(f_i(6'h24, 5'd11), PC_RESET, 32'h1003, DR_PAT, 1'b0, 1'b0);
    expect_reg("lh_off2",  5'd12, 32'hFFFF80FF);
    drive(f_i(6'h21, 5'd12), PC_RESET, 32'h1002, DR_PAT, 1'b0, 1'b0);
    expect_reg("lhu_off0", 5'd13, 32'h00007F01);
    drive(f_i(6'h25, 5'd13), PC_RESET, 32'h1000, DR_PAT, 1'b0, 1'b0);
    expect_reg("lw",       5'd14, DR_PAT);
    drive(f_i(6'h23, 5'd14), PC_RESET, 32'h1001, DR_PAT, 1'b0, 1'b0);
    drain();

    // movz: suppressed write still retires; taken write lands
    drive(f_i(6'h0D, 5'd7), PC_RESET, 32'h55, 32'd0, 1'b0, 1'b0);
    expect_reg("movz_off", 5'd7, 32'h55);
    drive(f_r(5'd7, 6'h0A), PC_RESET, 32'h7, 32'd0, 1'b0, 1'b0);
    drain();
    expect_reg("movz_on", 5'd7, 32'h7);
    drive(f_r(5'd7, 6'h0A), PC_RESET, 32'h7, 32'd0, 1'b1, 1'b0);
    drain();

    // Link writes: jal, bgezal not taken / taken, jalr with PC wrap
    expect_reg("jal", 5'd31, 32'h0000300C);
    drive(f_i(6'h03, 5'd0), 32'h00003008, 32'h0, 32'd0, 1'b0, 1'b0);
    drain();
    expect_reg("bgezal_nt", 5'd31, 32'h0000300C);
    drive(f_i(6'h01, 5'h11), 32'h00004000, 32'h0, 32'd0, 1'b0, 1'b0);
    check("bgezal_nt_we", {31'd0, s_we}, 32'd0);
    drain();
    expect_reg("bgezal_t", 5'd31, 32'h00004004);
    drive(f_i(6'h01, 5'h11), 32'h00004000, 32'h0, 32'd0, 1'b0, 1'b1);
    drain();
    drive(f_i(6'h09, 5'd20), PC_RESET, 32'h1, 32'd0, 1'b0, 1'b0);
    expect_reg("jalr_wrap", 5'd20, 32'h0);
    drive(f_r(5'd20, 6'h09), 32'hFFFFFFFC, 32'h0, 32'd0, 1'b0, 1'b0);
    check("jalr_wd", s_wd, 32'h0);
    drain();

    // Store produces no write
    expect_reg("sw_nowr", 5'd20, 32'h0);
    drive(f_i(6'h2B, 5'd20), PC_RESET, 32'h123, 32'd0, 1'b0, 1'b0);
    check("sw_we", {31'd0, s_we}, 32'd0);
    drain();

    // Same-cycle read of a register being written
    drive(f_i(6'h0D, 5'd9), PC_RESET, 32'h33, 32'd0, 1'b0, 1'b0);
    RA1 = 5'd9; RA2 = 5'd9;
    drive(f_r(5'd9, 6'h21), PC_RESET, 32'h5, 32'd0, 1'b0, 1'b0);
`ifdef WB_BYPASS_EN
    check("byp_rd1_same", s_rd1, 32'h5);
    check("byp_rd2_same", s_rd2, 32'h5);
`else
    check("nobyp_rd1_same", s_rd1, 32'h33);
    check("nobyp_rd2_same", s_rd2, 32'h33);
`endif
    check("rd1_next", RD1, 32'h5);
    check("rd2_next", RD2, 32'h5);
    drain();

    // Bubble: no write, no count
    drive(32'd0, PC_RESET, 32'h0, 32'd0, 1'b0, 1'b0);
    check("bubble_we", {31'd0, s_we}, 32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
